// File: rtl/mod_i2s_tx_pkg.sv
// Shared types and constants for the stereo I2S transmitter.
// A frame is 64 BCLK slots carrying {left, right} MSB first.
package pkg_i2s;

    localparam int FRAME_SLOTS = 64;
    localparam int CHAN_BITS   = 32;
    localparam int FRAME_W     = 2 * CHAN_BITS;

    typedef logic signed [CHAN_BITS-1:0] sample_t;
    typedef logic [5:0]                  slot_t;

    localparam slot_t SLOT_LAST    = slot_t'(FRAME_SLOTS - 1);
    localparam slot_t SLOT_FIRST_R = slot_t'(CHAN_BITS);

    // Left occupies the upper half so it is shifted out first.
    function automatic logic [FRAME_W-1:0] frame_word(input sample_t l, input sample_t r);
        return {l, r};
    endfunction

endpackage

// File: rtl/mod_i2s_tx_clkdiv.sv
// Bit-clock generator: toggles BCLK every CLK_DIV system clocks and flags
// the system-clock edge on which each rising/falling toggle takes effect.
module mod_clkdiv_strobe #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_bclk,
    output logic o_fall_stb,
    output logic o_rise_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             bclk_q;
    logic             bclk_d;
    logic             term;

    // Strobes are decoded from current state so the top can update its
    // outputs on the very edge where BCLK toggles.
    always_comb begin
        term       = (div_cnt_q == CNT_LAST);
        div_cnt_d  = term ? '0 : div_cnt_q + CNT_W'(1);
        bclk_d     = term ? ~bclk_q : bclk_q;
        o_rise_stb = term && !bclk_q;
        o_fall_stb = term && bclk_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign o_bclk = bclk_q;

endmodule

// File: rtl/mod_i2s_tx.sv
// Stereo Philips-I2S transmitter with a one-entry valid/ready holding register,
// 64-slot frame shifter and underrun (silence) insertion at frame boundaries.
module mod_i2s_tx
    import pkg_i2s::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic signed [CHAN_BITS-1:0] i_sample_l,
    input  logic signed [CHAN_BITS-1:0] i_sample_r,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_bclk,
    output logic                        o_lrclk,
    output logic                        o_sdata,
    output logic                        o_underrun
);

    logic fall_stb;
    logic rise_stb;

    mod_clkdiv_strobe #(
        .CLK_DIV(CLK_DIV)
    ) u_clkdiv (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .o_bclk    (o_bclk),
        .o_fall_stb(fall_stb),
        .o_rise_stb(rise_stb)
    );

    slot_t              slot_q;
    slot_t              slot_d;
    logic [FRAME_W-1:0] shreg_q;
    logic [FRAME_W-1:0] shreg_d;
    logic               lrclk_q;
    logic               lrclk_d;
    logic               sdata_q;
    logic               sdata_d;
    logic               ready_q;
    logic               ready_d;
    logic               underrun_q;
    logic               underrun_d;
    sample_t            hold_l_q;
    sample_t            hold_l_d;
    sample_t            hold_r_q;
    sample_t            hold_r_d;
    logic               boundary;
    logic               accept;

    always_comb begin
        boundary   = fall_stb && (slot_q == SLOT_LAST);
        accept     = i_valid && ready_q;
        slot_d     = slot_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        shreg_d    = shreg_q;
        ready_d    = ready_q;
        underrun_d = 1'b0;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;

        // Sending the shifter MSB before the reload gives the one-bit I2S
        // delay: slot 0 carries the previous frame's last bit.
        if (fall_stb) begin
            slot_d  = slot_q + slot_t'(1);
            lrclk_d = (slot_d >= SLOT_FIRST_R);
            sdata_d = shreg_q[FRAME_W-1];
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        end

        if (boundary) begin
            if (!ready_q) begin
                shreg_d = frame_word(hold_l_q, hold_r_q);
                ready_d = 1'b1;
            end else if (i_valid) begin
                shreg_d = frame_word(i_sample_l, i_sample_r);
            end else begin
                shreg_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (accept) begin
            hold_l_d = i_sample_l;
            hold_r_d = i_sample_r;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_q     <= SLOT_LAST;
            shreg_q    <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            shreg_q    <= shreg_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    // Holding data is qualified by ready_q, so it needs no reset.
    always_ff @(posedge i_clk) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(rise_stb && fall_stb));
        end
    end

    assign o_ready    = ready_q;
    assign o_lrclk    = lrclk_q;
    assign o_sdata    = sdata_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_mod_i2s_tx.sv
// Self-checking bench for mod_i2s_tx (CLK_DIV=2): a frame monitor rebuilds
// each transmitted 64-bit word and compares it with a queue of accepted pairs.
module tb_mod_i2s_tx;

    localparam int CLK_DIV = 2;
    localparam int BCLK_P  = 2 * CLK_DIV;
    localparam int FRAME_P = 128 * CLK_DIV;

    logic               clk;
    logic               rst;
    logic signed [31:0] i_sample_l;
    logic signed [31:0] i_sample_r;
    logic               i_valid;
    logic               o_ready;
    logic               o_bclk;
    logic               o_lrclk;
    logic               o_sdata;
    logic               o_underrun;

    mod_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sample_l(i_sample_l),
        .i_sample_r(i_sample_r),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_bclk    (o_bclk),
        .o_lrclk   (o_lrclk),
        .o_sdata   (o_sdata),
        .o_underrun(o_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    int          acc_cyc_q[$];
    int          acc_cnt = 0;
    int          cyc = 0;
    int          slot_m = 63;
    bit          fell_now = 0;
    int          frames_done = 0;
    int          underrun_cnt = 0;

    // Records every handshake; values sampled before the edge's updates land.
    task automatic accepter();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && i_valid && o_ready) begin
                sb_q.push_back({i_sample_l, i_sample_r});
                acc_cyc_q.push_back(cyc);
                acc_cnt++;
            end
        end
    endtask

    task automatic monitor();
        logic        prev_bclk = 1'b0;
        bit          in_frame = 0;
        bit          cur_uflow = 0;
        logic [63:0] cur_bits = '0;
        logic [63:0] exp_w;
        int          last_fall = -1;
        forever begin
            @(negedge clk);
            fell_now = 0;
            if (rst) begin
                prev_bclk = 1'b0;
                slot_m    = 63;
                in_frame  = 0;
                last_fall = -1;
                sb_q.delete();
            end else begin
                if (prev_bclk && !o_bclk) begin
                    fell_now = 1;
                    slot_m   = (slot_m + 1) % 64;
                    if (last_fall >= 0) begin
                        checks++;
                        if (cyc - last_fall != BCLK_P) begin
                            errors++;
                            $display("FAIL bclk_period got=%0d exp=%0d", cyc - last_fall, BCLK_P);
                        end
                    end
                    last_fall = cyc;
                    checks++;
                    if (o_lrclk !== (slot_m >= 32)) begin
                        errors++;
                        $display("FAIL lrclk slot=%0d got=%b", slot_m, o_lrclk);
                    end
                    if (slot_m == 0) begin
                        if (in_frame) begin
                            cur_bits[0] = o_sdata;
                            if (cur_uflow) begin
                                exp_w = '0;
                            end else if (sb_q.size() == 0) begin
                                exp_w = 64'hx;
                            end else begin
                                exp_w = sb_q.pop_front();
                            end
                            checks++;
                            if (cur_bits !== exp_w) begin
                                errors++;
                                $display("FAIL frame_word got=%h exp=%h", cur_bits, exp_w);
                            end
                            frames_done++;
                        end else begin
                            checks++;
                            if (o_sdata !== 1'b0) begin
                                errors++;
                                $display("FAIL first_slot0_sdata got=%b exp=0", o_sdata);
                            end
                        end
                        in_frame  = 1;
                        cur_uflow = o_underrun;
                        cur_bits  = '0;
                    end else if (in_frame) begin
                        cur_bits[64 - slot_m] = o_sdata;
                    end
                end
                if (o_underrun) begin
                    underrun_cnt++;
                    checks++;
                    if (!(fell_now && slot_m == 0)) begin
                        errors++;
                        $display("FAIL underrun_position slot=%0d fell=%0d", slot_m, fell_now);
                    end
                end
                prev_bclk = o_bclk;
            end
        end
    endtask

    task automatic wait_slot(input int target, input string tag);
        bit found = 0;
        for (int i = 0; i < 3 * FRAME_P && !found; i++) begin
            @(negedge clk);
            #1;
            if (fell_now && slot_m == target) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s timeout waiting for slot %0d", tag, target);
        end
    endtask

    task automatic test_reset();
        logic exp_bclk[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int   uf0;
        repeat (3) @(negedge clk);
        #1;
        checks += 5;
        if (o_bclk !== 1'b0)     begin errors++; $display("FAIL rst_bclk got=%b exp=0", o_bclk); end
        if (o_lrclk !== 1'b0)    begin errors++; $display("FAIL rst_lrclk got=%b exp=0", o_lrclk); end
        if (o_sdata !== 1'b0)    begin errors++; $display("FAIL rst_sdata got=%b exp=0", o_sdata); end
        if (o_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
        if (o_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b exp=0", o_underrun); end
        rst = 1'b0;
        uf0 = underrun_cnt;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks += 2;
            if (o_bclk !== exp_bclk[i]) begin
                errors++;
                $display("FAIL first_bclk edge=%0d got=%b exp=%b", i + 1, o_bclk, exp_bclk[i]);
            end
            if (o_ready !== 1'b1) begin
                errors++;
                $display("FAIL first_ready edge=%0d got=%b exp=1", i + 1, o_ready);
            end
        end
        checks += 2;
        if (o_underrun !== 1'b1) begin errors++; $display("FAIL first_underrun got=%b exp=1", o_underrun); end
        if (o_sdata !== 1'b0)    begin errors++; $display("FAIL first_sdata got=%b exp=0", o_sdata); end
        @(posedge clk);
        #1;
        checks++;
        if (o_underrun !== 1'b0) begin errors++; $display("FAIL underrun_width got=%b exp=0", o_underrun); end
        wait_slot(0, "reset_frame");
        checks++;
        if (underrun_cnt - uf0 != 2) begin
            errors++;
            $display("FAIL reset_underrun_count got=%0d exp=2", underrun_cnt - uf0);
        end
    endtask

    task automatic test_basic_frame();
        i_sample_l = 32'sh8000_0001;
        i_sample_r = 32'sh7FFF_FFFE;
        i_valid    = 1'b1;
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after_accept got=%b exp=0", o_ready); end
        wait_slot(0, "basic_load");
        checks += 2;
        if (o_ready !== 1'b1)    begin errors++; $display("FAIL basic_ready_boundary got=%b exp=1", o_ready); end
        if (o_underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got=%b exp=0", o_underrun); end
        wait_slot(1, "basic_s1");
        checks++;
        if (o_sdata !== 1'b1) begin errors++; $display("FAIL basic_slot1 got=%b exp=1", o_sdata); end
        wait_slot(2, "basic_s2");
        checks++;
        if (o_sdata !== 1'b0) begin errors++; $display("FAIL basic_slot2 got=%b exp=0", o_sdata); end
        wait_slot(31, "basic_s31");
        checks++;
        if (o_lrclk !== 1'b0) begin errors++; $display("FAIL basic_lrclk31 got=%b exp=0", o_lrclk); end
        wait_slot(32, "basic_s32");
        checks += 2;
        if (o_sdata !== 1'b1) begin errors++; $display("FAIL basic_slot32 got=%b exp=1", o_sdata); end
        if (o_lrclk !== 1'b1) begin errors++; $display("FAIL basic_lrclk32 got=%b exp=1", o_lrclk); end
        wait_slot(33, "basic_s33");
        checks++;
        if (o_sdata !== 1'b0) begin errors++; $display("FAIL basic_slot33 got=%b exp=0", o_sdata); end
        wait_slot(0, "basic_next");
        checks++;
        if (o_sdata !== 1'b0) begin errors++; $display("FAIL basic_right_lsb got=%b exp=0", o_sdata); end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] l = 32'sh1000_0000;
        logic signed [31:0] r = -32'sh1;
        int base_acc;
        int last;
        int n_acc;
        acc_cyc_q.delete();
        base_acc   = acc_cnt;
        last       = acc_cnt;
        i_sample_l = l;
        i_sample_r = r;
        i_valid    = 1'b1;
        for (int c = 0; c < 4 * FRAME_P + 8; c++) begin
            @(negedge clk);
            #1;
            if (acc_cnt != last) begin
                last       = acc_cnt;
                l          = l + 1;
                r          = r - 1;
                i_sample_l = l;
                i_sample_r = r;
            end
        end
        i_valid = 1'b0;
        n_acc   = acc_cnt - base_acc;
        checks++;
        if (n_acc < 4 || n_acc > 5) begin
            errors++;
            $display("FAIL b2b_accept_count got=%0d exp=4..5", n_acc);
        end
        for (int i = 1; i + 1 < acc_cyc_q.size(); i++) begin
            checks++;
            if (acc_cyc_q[i+1] - acc_cyc_q[i] != FRAME_P) begin
                errors++;
                $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i, acc_cyc_q[i+1] - acc_cyc_q[i], FRAME_P);
            end
        end
        wait_slot(0, "b2b_drain1");
        wait_slot(0, "b2b_drain2");
        checks += 2;
        if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d exp=0", sb_q.size()); end
        if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%b exp=1", o_ready); end
    endtask

    task automatic test_bypass();
        int base_acc;
        int uf0;
        int fd0;
        wait_slot(63, "bypass_s63");
        base_acc = acc_cnt;
        uf0      = underrun_cnt;
        repeat (BCLK_P - 1) @(negedge clk);
        #1;
        i_sample_l = 32'shDEAD_BEEF;
        i_sample_r = 32'sh1234_5678;
        i_valid    = 1'b1;
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        fd0     = frames_done;
        checks += 5;
        if (!(fell_now && slot_m == 0)) begin errors++; $display("FAIL bypass_boundary slot=%0d fell=%0d", slot_m, fell_now); end
        if (o_ready !== 1'b1)           begin errors++; $display("FAIL bypass_ready got=%b exp=1", o_ready); end
        if (o_underrun !== 1'b0)        begin errors++; $display("FAIL bypass_underrun got=%b exp=0", o_underrun); end
        if (underrun_cnt != uf0)        begin errors++; $display("FAIL bypass_underrun_cnt got=%0d exp=%0d", underrun_cnt, uf0); end
        if (acc_cnt != base_acc + 1)    begin errors++; $display("FAIL bypass_accepts got=%0d exp=%0d", acc_cnt, base_acc + 1); end
        wait_slot(0, "bypass_done");
        checks += 2;
        if (frames_done != fd0 + 1) begin errors++; $display("FAIL bypass_frames got=%0d exp=%0d", frames_done, fd0 + 1); end
        if (sb_q.size() != 0)       begin errors++; $display("FAIL bypass_pending got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int uf0;
        int fd0;
        i_sample_l = 32'sh0F0F_0F0F;
        i_sample_r = 32'shFFFF_FFFF;
        i_valid    = 1'b1;
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        wait_slot(0, "mid_load_a");
        i_sample_l = 32'sh7777_7777;
        i_sample_r = 32'sh5555_5555;
        i_valid    = 1'b1;
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        wait_slot(40, "mid_s40");
        repeat (CLK_DIV) @(negedge clk);
        #1;
        checks += 4;
        if (o_bclk !== 1'b1)  begin errors++; $display("FAIL mid_pre_bclk got=%b exp=1", o_bclk); end
        if (o_lrclk !== 1'b1) begin errors++; $display("FAIL mid_pre_lrclk got=%b exp=1", o_lrclk); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_ready got=%b exp=0", o_ready); end
        if (o_sdata !== 1'b1) begin errors++; $display("FAIL mid_pre_sdata got=%b exp=1", o_sdata); end
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (o_bclk !== 1'b0)     begin errors++; $display("FAIL mid_rst_bclk got=%b exp=0", o_bclk); end
        if (o_lrclk !== 1'b0)    begin errors++; $display("FAIL mid_rst_lrclk got=%b exp=0", o_lrclk); end
        if (o_sdata !== 1'b0)    begin errors++; $display("FAIL mid_rst_sdata got=%b exp=0", o_sdata); end
        if (o_ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", o_ready); end
        if (o_underrun !== 1'b0) begin errors++; $display("FAIL mid_rst_underrun got=%b exp=0", o_underrun); end
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        uf0 = underrun_cnt;
        fd0 = frames_done;
        wait_slot(0, "mid_first");
        checks += 2;
        if (o_underrun !== 1'b1) begin errors++; $display("FAIL mid_first_underrun got=%b exp=1", o_underrun); end
        if (o_sdata !== 1'b0)    begin errors++; $display("FAIL mid_first_sdata got=%b exp=0", o_sdata); end
        wait_slot(0, "mid_second");
        checks += 3;
        if (underrun_cnt != uf0 + 2) begin errors++; $display("FAIL mid_underrun_cnt got=%0d exp=%0d", underrun_cnt, uf0 + 2); end
        if (frames_done != fd0 + 1)  begin errors++; $display("FAIL mid_frames got=%0d exp=%0d", frames_done, fd0 + 1); end
        if (sb_q.size() != 0)        begin errors++; $display("FAIL mid_pending got=%0d exp=0", sb_q.size()); end
    endtask

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_sample_l = '0;
        i_sample_r = '0;
        fork
            accepter();
            monitor();
        join_none
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_bypass();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_i2s_tx.md
# mod_i2s_tx

Stereo I2S transmitter that serialises signed 32-bit samples onto a DAC link. Sits directly downstream of `mod_sinesource` and the later mixer. It takes left/right samples through a one-entry valid/ready buffer and drives BCLK, LRCLK and SDATA in Philips I2S format with 32 bit slots per channel. The falling edge of `o_ready` (sample consumed) is also the pacing signal for the upstream time counter.

## Interface
- `CLK_DIV`, default 4: `i_clk` cycles per BCLK half-period; legal range ≥1.
- `i_clk` in, 1: system clock.
- `i_rst` in, 1: reset, asynchronous, active-high.
- `i_sample_l` in, signed 32: left sample.
- `i_sample_r` in, signed 32: right sample.
- `i_valid` in, 1: sample pair valid.
- `o_ready` out, 1: holding register empty. A pair is accepted on any `i_clk` edge where `i_valid && o_ready`.
- `o_bclk` out, 1: bit clock.
- `o_lrclk` out, 1: word select; 0 = left, 1 = right.
- `o_sdata` out, 1: serial data.
- `o_underrun` out, 1: one-cycle pulse when a frame starts with no sample available.

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1. At the terminal count, `o_bclk` toggles and `div_cnt` returns to 0.
- **Slots.** Each falling BCLK toggle advances `slot` 0..63, wrapping from 63 to 0.
  - Every output change happens in the same `i_clk` edge as a falling toggle.
- **LRCLK.** `o_lrclk` is 0 for slots 0..31 and 1 for slots 32..63.
- **Frame word.** F = {L, R}, 64 bits, MSB first.
  - In slot k ≥ 1, `o_sdata` = F[63-(k-1)].
  - In slot 0, `o_sdata` = previous frame's F[0], the right-channel LSB. This is the I2S one-bit delay.
- **Holding register.**
  - An accept stores L/R and deasserts `o_ready` on the following cycle.
  - Entering slot 0 (the frame boundary), the holding content moves to the active frame and `o_ready` reasserts.
- **Boundary cases.**
  - Holding empty and `i_valid` high in the boundary cycle: the incoming pair bypasses directly into the active frame. No underrun; `o_ready` stays 1.
  - Holding empty and no `i_valid` at the boundary: the active frame becomes all zeros (silence, not repeat) and `o_underrun` pulses for 1 cycle.
  - Holding full: `o_ready` = 0 and `i_valid` is ignored. No overwrite.
- **Arithmetic.** Samples are passed bit-exact with no scaling, truncation or dither. Two's complement is preserved because transmission is MSB first.
- **Reset.** Reset mid-frame immediately returns every output and register to its reset value. Any pending sample is discarded.

## Timing
- **Reset values:**
  - `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, `o_ready`=1, `o_underrun`=0.
  - `div_cnt`=0, `slot`=63, active frame = 0.
- **First BCLK edges after reset deassertion:**
  - Rising toggle on the CLK_DIV-th `i_clk` rising edge.
  - Falling toggle, entering slot 0, on the 2·CLK_DIV-th edge.
- **Periods:**
  - BCLK period = 2·CLK_DIV cycles.
  - Frame = 128·CLK_DIV cycles.
- **Latency.** From the frame boundary that loads a pair, the left MSB appears one BCLK later (slot 1), and the right LSB appears at slot 0 of the next frame.
- **Registered outputs.** All outputs are registered. `o_ready` changes only on an accept or at a boundary.
- **Handshake rate.** At most one accept per frame. Upstream may hold `i_valid` high indefinitely.

## Structure
- **Package `pkg_i2s`:**
  - `FRAME_SLOTS`=64 and `CHAN_BITS`=32.
  - `typedef logic signed [31:0] sample_t`.
  - `typedef logic [5:0] slot_t`.
- **Sub-module `mod_clkdiv_strobe`:**
  - Takes `CLK_DIV`, `i_clk`, `i_rst`.
  - Outputs `o_bclk`, `o_fall_stb` and `o_rise_stb`, each strobe one `i_clk` cycle wide.
  - `mod_i2s_tx` uses `o_fall_stb` to advance slots.
- **Top-level contents:** slot counter, 64-bit shift register plus a 1-bit delay flop, holding register, and underrun logic.

## Test plan
- **Reset state.** CLK_DIV=2, reset release.
  - First BCLK rise at cycle 2, fall at cycle 4.
  - `o_ready`=1 throughout.
  - No sample supplied, so at slot 0 `o_underrun` pulses once and `o_sdata` stays 0 for the frame.
- **Basic frame.** L=32'h8000_0001, R=32'h7FFF_FFFE accepted before the boundary.
  - Captured slots 1..63: left 1000…0 then `o_sdata`=1 at slot 32.
  - Next frame slot 0 carries 0 (right LSB).
  - `o_lrclk` flips at the slot-32 falling edge.
- **Back-pressure.** Hold `i_valid`=1 with incrementing data.
  - Exactly one accept per frame, at boundary spacing of 256 cycles for CLK_DIV=2.
  - No pair lost or duplicated.
- **Bypass.** `i_valid` asserted exactly in the boundary cycle with holding empty.
  - The pair is transmitted in that frame.
  - `o_underrun` stays 0.
- **Reset mid-frame.** Assert `i_rst` at slot 40 with holding full.
  - Outputs return to reset values asynchronously.
  - After release, the first frame is silent with an underrun pulse; the old pair is never sent.
